proc_control_unit: RTL and testbench
====================================

Name: proc_control_unit

Overview:
- Multicycle control FSM for the 16-bit processor datapath: registers r0..r6, r7 = PC, address register, 10-bit IR, A/G ALU registers and a shared bus.
- Sequences fetch, decode and execute through a 3-bit time-step counter.
- Drives every bus-source select, register load enable, ALU op and memory strobe.
- Exposes Tstep and ALUop for board debug (7-seg counter digit, ALUop LEDs).

Parameters:
- none (opcode and ALUop encodings fixed below)

Ports:
- Clock  in  1  system clock, rising edge
- Resetn  in  1  asynchronous active-low reset
- Run  in  1  start/continue execution; sampled only in T0
- IR  in  10  datapath IR contents: [9:6] opcode, [5:3] X, [2:0] Y; valid from T3
- GNZ  in  1  1 when datapath G register is non-zero
- Rin  out  8  one-hot load enable for r0..r7
- Rout  out  8  one-hot bus drive for r0..r7
- Ain, Gin, Gout  out  1 each  A load, G load, G drives bus
- DINout  out  1  memory data-in drives bus
- IRin  out  1  IR loads from DIN
- AddrIn  out  1  address register loads from bus
- DoutIn  out  1  data-out register loads from bus
- W_D  out  1  memory write enable
- incr_pc  out  1  r7 <= r7+1 at next edge
- ALUop  out  3  ALU function (valid whenever Gin=1; 000 otherwise)
- Done  out  1  last step of current instruction
- Tstep  out  3  current time step (0..5)

Behaviour:
- State: Tstep register only; all other outputs are combinational from Tstep, IR, Run and GNZ. At most one bus source is active per step.
- Reset: Resetn low forces Tstep=0 asynchronously and all outputs 0, regardless of Run. Deassertion is synchronous to the next edge. Reset mid-instruction abandons it; no partial write is completed. The datapath owns r7's reset.
- Step advance: Tstep increments each clock. If Done=1, Tstep returns to 0 at the next edge. In T0 with Run=0, Tstep holds at 0 and all outputs are 0.
- Fetch (all opcodes):
  - T0 (Run=1): Rout[7], AddrIn, incr_pc.
  - T1: idle, synchronous RAM latency.
  - T2: IRin.
- Execute, with X=IR[5:3] and Y=IR[2:0]:
  - 0000 ld: T3 Rout[Y], AddrIn. T4 idle. T5 DINout, Rin[X], Done.
  - 0001 st: T3 Rout[Y], AddrIn. T4 Rout[X], DoutIn, W_D, Done.
  - 0010 mvnz: T3 Done. If GNZ=1, also Rout[Y], Rin[X]; otherwise no register write.
  - 0011 mv: T3 Rout[Y], Rin[X], Done.
  - 0100 mvi: T3 Rout[7], AddrIn, incr_pc. T4 idle. T5 DINout, Rin[X], Done.
  - 0101 add / 0110 sub / 0111 or / 1000 slt / 1001 sll / 1010 srl: T3 Rout[X], Ain. T4 Rout[Y], Gin, ALUop. T5 Gout, Rin[X], Done.
  - ALUop encoding: add 000, sub 001, or 010, slt 011, sll 100, srl 101.
  - 1011..1111 (undefined): T3 Done only; treated as nop.
- X=7 or Y=7 is legal: writing r7 is a jump. incr_pc never coincides with Rin[7].
- Tstep never exceeds 5; values 6/7 are unreachable. If one is reached, it is treated as Done with all other outputs 0.
- Instruction latency: 4 cycles (mv, mvnz, nop), 5 (st), 6 (ld, mvi, ALU ops).

Test Plan:
- Reset mid-instruction: assert Resetn=0 during T4 of add -> Tstep=0 and all outputs 0 immediately, before the next edge. Release with Run=0 -> stays in T0 with outputs 0.
- mvi r2,#0x00A5 (IR=0100_010_000), Run=1 -> T0 Rout=0x80, AddrIn, incr_pc; T2 IRin; T3 Rout=0x80, incr_pc; T5 DINout, Rin=0x04, Done; next cycle Tstep=0.
- add r0,r1 (IR=0101_000_001) -> T3 Rout=0x01, Ain; T4 Rout=0x02, Gin, ALUop=000; T5 Gout, Rin=0x01, Done. Repeat for srl (IR=1010_...) -> ALUop=101 in T4 only.
- st r3,[r4] (IR=0001_011_100) -> T3 Rout=0x10, AddrIn; T4 Rout=0x08, DoutIn, W_D=1, Done; W_D=0 in every other step.
- mvnz r5,r6 (IR=0010_101_110): with GNZ=0 -> T3 Done only, Rin=0; with GNZ=1 -> T3 Rout=0x40, Rin=0x20, Done.
- Opcode 1111 -> Done at T3 with no Rin/W_D. Run dropped while Done=1 -> Tstep parks at 0 with outputs 0 until Run=1.

Source files
------------

// File: rtl/proc_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module : proc_control_unit_if
// Brief  : Control bundle between the multicycle control FSM and the 16-bit
//          datapath. The control unit takes the master side: it samples
//          run/ir/gnz and drives every select, load enable and strobe.
// Rev    : 1.0  initial release
// ============================================================================
interface proc_control_unit_if;
  logic       run;
  logic [9:0] ir;
  logic       gnz;
  logic [7:0] rin;
  logic [7:0] rout;
  logic       ain;
  logic       gin;
  logic       gout;
  logic       dinout;
  logic       irin;
  logic       addrin;
  logic       doutin;
  logic       w_d;
  logic       incr_pc;
  logic [2:0] aluop;
  logic       done;
  logic [2:0] tstep;

  // Control unit side
  modport master (
    input  run, ir, gnz,
    output rin, rout, ain, gin, gout, dinout, irin, addrin, doutin,
           w_d, incr_pc, aluop, done, tstep
  );

  // Datapath side
  modport slave (
    output run, ir, gnz,
    input  rin, rout, ain, gin, gout, dinout, irin, addrin, doutin,
           w_d, incr_pc, aluop, done, tstep
  );
endinterface
`default_nettype wire

// File: rtl/proc_control_unit.sv
`default_nettype none
// ============================================================================
// Module : proc_control_unit
// Brief  : Multicycle control FSM. A 3-bit time-step register sequences
//          fetch (T0..T2) and execute (T3..T5); every datapath control is
//          decoded combinationally from Tstep, IR, Run and GNZ.
// Rev    : 1.0  initial release
// ============================================================================
module proc_control_unit (
  input  logic                clk_i,
  input  logic                resetn_i,
  proc_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7
  } tstep_t;

  localparam logic [3:0] c_OP_LD   = 4'b0000;
  localparam logic [3:0] c_OP_ST   = 4'b0001;
  localparam logic [3:0] c_OP_MVNZ = 4'b0010;
  localparam logic [3:0] c_OP_MV   = 4'b0011;
  localparam logic [3:0] c_OP_MVI  = 4'b0100;
  localparam logic [3:0] c_OP_ADD  = 4'b0101;
  localparam logic [3:0] c_OP_SRL  = 4'b1010;
  localparam logic [7:0] c_PC_SEL  = 8'h80;

  tstep_t     tstep_q, tstep_d;

  logic [3:0] w_op;
  logic [7:0] w_x_oh, w_y_oh;
  logic       w_is_alu;
  logic [3:0] w_alu_idx;

  logic [7:0] w_rin, w_rout;
  logic       w_ain, w_gin, w_gout, w_dinout, w_irin, w_addrin, w_doutin;
  logic       w_wd, w_incr_pc, w_done;
  logic [2:0] w_aluop;

  assign w_op      = bus.ir[9:6];
  assign w_x_oh    = 8'd1 << bus.ir[5:3];
  assign w_y_oh    = 8'd1 << bus.ir[2:0];
  assign w_is_alu  = (w_op >= c_OP_ADD) && (w_op <= c_OP_SRL);
  // ALU opcodes are contiguous from add, so the ALUop is the offset from add
  assign w_alu_idx = w_op - c_OP_ADD;

  // Decode all datapath controls for the current step; reset forces them low
  always_comb begin
    w_rin     = '0;
    w_rout    = '0;
    w_ain     = 1'b0;
    w_gin     = 1'b0;
    w_gout    = 1'b0;
    w_dinout  = 1'b0;
    w_irin    = 1'b0;
    w_addrin  = 1'b0;
    w_doutin  = 1'b0;
    w_wd      = 1'b0;
    w_incr_pc = 1'b0;
    w_aluop   = 3'b000;
    w_done    = 1'b0;
    unique case (tstep_q)
      T0: begin
        if (bus.run) begin
          w_rout    = c_PC_SEL;
          w_addrin  = 1'b1;
          w_incr_pc = 1'b1;
        end
      end
      T1: ; // synchronous RAM read latency
      T2: w_irin = 1'b1;
      T3: begin
        if (w_is_alu) begin
          w_rout = w_x_oh;
          w_ain  = 1'b1;
        end else begin
          case (w_op)
            c_OP_LD, c_OP_ST: begin
              w_rout   = w_y_oh;
              w_addrin = 1'b1;
            end
            c_OP_MVNZ: begin
              w_done = 1'b1;
              if (bus.gnz) begin
                w_rout = w_y_oh;
                w_rin  = w_x_oh;
              end
            end
            c_OP_MV: begin
              w_rout = w_y_oh;
              w_rin  = w_x_oh;
              w_done = 1'b1;
            end
            c_OP_MVI: begin
              w_rout    = c_PC_SEL;
              w_addrin  = 1'b1;
              w_incr_pc = 1'b1;
            end
            default: w_done = 1'b1; // undefined opcodes execute as nop
          endcase
        end
      end
      T4: begin
        if (w_is_alu) begin
          w_rout  = w_y_oh;
          w_gin   = 1'b1;
          w_aluop = w_alu_idx[2:0];
        end else if (w_op == c_OP_ST) begin
          w_rout   = w_x_oh;
          w_doutin = 1'b1;
          w_wd     = 1'b1;
          w_done   = 1'b1;
        end else if ((w_op != c_OP_LD) && (w_op != c_OP_MVI)) begin
          w_done = 1'b1; // unreachable for these opcodes; recover to T0
        end
      end
      T5: begin
        w_done = 1'b1;
        if (w_is_alu) begin
          w_gout = 1'b1;
          w_rin  = w_x_oh;
        end else if ((w_op == c_OP_LD) || (w_op == c_OP_MVI)) begin
          w_dinout = 1'b1;
          w_rin    = w_x_oh;
        end
      end
      default: w_done = 1'b1; // T6/T7 unreachable; end the instruction
    endcase
    if (!resetn_i) begin
      w_rin     = '0;
      w_rout    = '0;
      w_ain     = 1'b0;
      w_gin     = 1'b0;
      w_gout    = 1'b0;
      w_dinout  = 1'b0;
      w_irin    = 1'b0;
      w_addrin  = 1'b0;
      w_doutin  = 1'b0;
      w_wd      = 1'b0;
      w_incr_pc = 1'b0;
      w_aluop   = 3'b000;
      w_done    = 1'b0;
    end
  end

  // Next step: wrap after Done, park in T0 while Run is low, else advance
  always_comb begin
    tstep_d = tstep_t'(tstep_q + 3'd1);
    if (w_done || ((tstep_q == T0) && !bus.run)) begin
      tstep_d = T0;
    end
  end

  // Time-step register
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      tstep_q <= T0;
    end else begin
      tstep_q <= tstep_d;
    end
  end

  assign bus.rin     = w_rin;
  assign bus.rout    = w_rout;
  assign bus.ain     = w_ain;
  assign bus.gin     = w_gin;
  assign bus.gout    = w_gout;
  assign bus.dinout  = w_dinout;
  assign bus.irin    = w_irin;
  assign bus.addrin  = w_addrin;
  assign bus.doutin  = w_doutin;
  assign bus.w_d     = w_wd;
  assign bus.incr_pc = w_incr_pc;
  assign bus.aluop   = w_aluop;
  assign bus.done    = w_done;
  assign bus.tstep   = tstep_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_control_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_proc_control_unit
// Brief  : Self-checking bench for proc_control_unit. Each instruction is
//          expanded by a reference model into its list of per-step control
//          words, which are compared against the DUT every cycle.
// Rev    : 1.0  initial release
// ============================================================================
module tb_proc_control_unit;

  // Flag positions inside the 9-bit strobe field of a control word
  localparam logic [8:0] c_F_AIN  = 9'b1_0000_0000;
  localparam logic [8:0] c_F_GIN  = 9'b0_1000_0000;
  localparam logic [8:0] c_F_GOUT = 9'b0_0100_0000;
  localparam logic [8:0] c_F_DIN  = 9'b0_0010_0000;
  localparam logic [8:0] c_F_IRIN = 9'b0_0001_0000;
  localparam logic [8:0] c_F_ADDR = 9'b0_0000_1000;
  localparam logic [8:0] c_F_DOUT = 9'b0_0000_0100;
  localparam logic [8:0] c_F_WD   = 9'b0_0000_0010;
  localparam logic [8:0] c_F_INC  = 9'b0_0000_0001;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  proc_control_unit_if bus ();

  proc_control_unit dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control word: {rin, rout, strobes, aluop, done, tstep}
  logic [31:0] w_obs;
  assign w_obs = {bus.rin, bus.rout,
                  bus.ain, bus.gin, bus.gout, bus.dinout, bus.irin,
                  bus.addrin, bus.doutin, bus.w_d, bus.incr_pc,
                  bus.aluop, bus.done, bus.tstep};

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [7:0] rin,
                                       input logic [7:0] rout,
                                       input logic [8:0] fl,
                                       input logic [2:0] alu,
                                       input logic dn);
    return {rin, rout, fl, alu, dn, 3'b000};
  endfunction

  // Reference model: expand one instruction into its sequence of steps
  function automatic void build_seq(input logic [3:0] op, input logic [2:0] x,
                                    input logic [2:0] y, input logic gnz,
                                    output logic [31:0] seq [$]);
    logic [7:0] xo, yo;
    logic [2:0] alu;
    xo = 8'd1 << x;
    yo = 8'd1 << y;
    seq = {};
    seq.push_back(word(0, 8'h80, c_F_ADDR | c_F_INC, 0, 0));
    seq.push_back(word(0, 0, 0, 0, 0));
    seq.push_back(word(0, 0, c_F_IRIN, 0, 0));
    case (op)
      4'd0: begin  // ld
        seq.push_back(word(0, yo, c_F_ADDR, 0, 0));
        seq.push_back(word(0, 0, 0, 0, 0));
        seq.push_back(word(xo, 0, c_F_DIN, 0, 1));
      end
      4'd1: begin  // st
        seq.push_back(word(0, yo, c_F_ADDR, 0, 0));
        seq.push_back(word(0, xo, c_F_DOUT | c_F_WD, 0, 1));
      end
      4'd2: seq.push_back(gnz ? word(xo, yo, 0, 0, 1) : word(0, 0, 0, 0, 1));
      4'd3: seq.push_back(word(xo, yo, 0, 0, 1));
      4'd4: begin  // mvi
        seq.push_back(word(0, 8'h80, c_F_ADDR | c_F_INC, 0, 0));
        seq.push_back(word(0, 0, 0, 0, 0));
        seq.push_back(word(xo, 0, c_F_DIN, 0, 1));
      end
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
        case (op)
          4'd5:    alu = 3'b000;  // add
          4'd6:    alu = 3'b001;  // sub
          4'd7:    alu = 3'b010;  // or
          4'd8:    alu = 3'b011;  // slt
          4'd9:    alu = 3'b100;  // sll
          default: alu = 3'b101;  // srl
        endcase
        seq.push_back(word(0, xo, c_F_AIN, 0, 0));
        seq.push_back(word(0, yo, c_F_GIN, alu, 0));
        seq.push_back(word(xo, 0, c_F_GOUT, 0, 1));
      end
      default: seq.push_back(word(0, 0, 0, 0, 1));
    endcase
  endfunction

  // Run one instruction from T0; if abort_at >= 0, reset during that step
  task automatic run_instr(input string tag, input logic [3:0] op,
                           input logic [2:0] x, input logic [2:0] y,
                           input logic gnz, input int abort_at);
    logic [31:0] seq [$];
    build_seq(op, x, y, gnz, seq);
    for (int k = 0; k < seq.size(); k++) begin
      bus.run = (k == 0) ? 1'b1 : 1'($urandom);
      bus.ir  = (k >= 3) ? {op, x, y} : 10'($urandom);
      bus.gnz = (k == 3) ? gnz : 1'($urandom);
      @(negedge clk);
      check_eq($sformatf("%s_T%0d", tag, k), w_obs, seq[k] | 32'(k));
      if (k == abort_at) begin
        #2 resetn = 1'b0;
        bus.run = 1'b1;
        #1 check_eq({tag, "_async_rst"}, w_obs, 32'd0);
        @(posedge clk);
        #2 bus.run = 1'b0;
        resetn = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Hold Run low and confirm the FSM parks in T0 with everything quiet
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      bus.run = 1'b0;
      bus.ir  = 10'($urandom);
      bus.gnz = 1'($urandom);
      @(negedge clk);
      check_eq(tag, w_obs, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    bus.run = 1'b1;
    bus.ir  = 10'h3FF;
    bus.gnz = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset_state", w_obs, 32'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    bus.run = 1'b0;
    @(posedge clk);
    #1;

    // Reset during T4 of add, then release with Run low
    run_instr("add_abort", 4'd5, 3'd0, 3'd1, 1'b0, 4);
    @(posedge clk);
    #1;
    idle("post_reset_idle", 3);

    run_instr("mvi", 4'b0100, 3'd2, 3'd0, 1'b0, -1);
    run_instr("add", 4'b0101, 3'd0, 3'd1, 1'b0, -1);
    run_instr("srl", 4'b1010, 3'd3, 3'd6, 1'b1, -1);
    run_instr("st", 4'b0001, 3'd3, 3'd4, 1'b1, -1);
    run_instr("mvnz0", 4'b0010, 3'd5, 3'd6, 1'b0, -1);
    run_instr("mvnz1", 4'b0010, 3'd5, 3'd6, 1'b1, -1);
    run_instr("nop15", 4'b1111, 3'd7, 3'd7, 1'b1, -1);
    idle("park", 3);
    run_instr("ld_r7", 4'b0000, 3'd7, 3'd7, 1'b0, -1);
    run_instr("mv_jmp", 4'b0011, 3'd7, 3'd2, 1'b0, -1);

    for (int i = 0; i < 60; i++) begin
      run_instr($sformatf("rnd%0d", i), 4'($urandom), 3'($urandom),
                3'($urandom), 1'($urandom), -1);
      if ($urandom_range(0, 3) == 0) idle("rnd_park", $urandom_range(1, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
